inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit for the single-cycle MIPS core. It holds the PC and issues word requests to instruction memory with a variable-latency request/acknowledge handshake. It presents each returned 32-bit instruction, with its PC, to the field-decode stage through a valid/ready handshake. The decode/execute stage feeds it redirect information (branch, j/jal, jr), which is applied when the instruction is consumed.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC of the first fetch after reset.
- NOP_WORD, 32'h0000_0000, instruction substituted when a fetch is faulted.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high with stable imem_addr until imem_ack.
- imem_addr  out  32  word address of the fetch (always pc_r).
- imem_ack  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched word.
- Instruction  out  32  instruction presented to decode.
- pc  out  32  PC of Instruction.
- pc4  out  32  pc + 4, modulo 2^32.
- inst_valid  out  1  Instruction/pc are valid.
- inst_ready  in  1  decode consumes the instruction this cycle.
- br_take  in  1  consumed instruction is a taken branch.
- imm16  in  16  branch offset of the consumed instruction.
- jmp  in  1  consumed instruction is j/jal.
- Target  in  26  jump index of the consumed instruction.
- jr  in  1  consumed instruction is jr/jalr.
- jr_addr  in  32  register target for jr.
- inst_cnt  out  32  count of consumed instructions.
- adel  out  1  exists only with IFU_ALIGN_CHK_EN; see Configuration.

## Operation
- FSM states: RST, FETCH, VALID.
- RST: imem_req=0. Go to FETCH on the next clock.
- FETCH: imem_req=1, imem_addr=pc_r. On imem_ack, capture imem_rdata into inst_r and go to VALID. Otherwise stay in FETCH.
- VALID: inst_valid=1. If inst_ready is low, hold all outputs stable. If inst_ready is high:
  - pc_r <= next_pc
  - inst_cnt += 1 (wraps at 2^32)
  - go to FETCH
- Redirect inputs are sampled only in a VALID cycle with inst_ready=1. They are ignored in every other cycle.
- next_pc priority is jr > jmp > br_take > sequential:
  - jr: jr_addr.
  - jmp: {pc4[31:28], Target, 2'b00}.
  - br_take: pc4 + (sign-extend(imm16) << 2), 32-bit, overflow discarded.
  - sequential: pc4.
- No delay slot. The instruction following a redirect is fetched from next_pc.
- imem_ack outside FETCH is ignored.

## Timing
- Reset values: state=RST, pc_r=RESET_PC, inst_r=NOP_WORD, inst_valid=0, imem_req=0, inst_cnt=0, adel=0. These hold asynchronously while rst_n=0.
- The first imem_req is asserted one cycle after rst_n deasserts.
- With imem_ack and inst_ready both high at first opportunity, throughput is 1 instruction per 2 cycles.
- Each cycle of imem_ack delay adds one cycle. Each cycle of inst_ready delay adds one cycle.
- pc4 is combinational from pc_r.
- pc_r = 32'hFFFF_FFFC gives pc4 = 0. There is no fault on wrap.
- Reset asserted mid-fetch abandons the request. A late imem_ack after reset release is discarded because the FSM is in RST.

## Configuration
- IFU_ALIGN_CHK_EN defined:
  - If next_pc[1:0] != 0 at the update, pc_r is still loaded and the next FETCH issues no imem_req.
  - The FSM goes directly to VALID with Instruction=NOP_WORD and adel=1.
  - adel clears when that slot is consumed.
- IFU_ALIGN_CHK_EN undefined:
  - There is no adel port.
  - next_pc[1:0] is forced to 2'b00 before loading pc_r.

## Test plan
- Reset, imem_ack=1, inst_ready=1, sequential code: pc = 3000, 3004, 3008 on every second cycle; inst_cnt=3 after the third accept.
- imem_ack delayed 3 cycles: imem_addr and imem_req remain stable through the wait; inst_valid rises the cycle after ack; Instruction = imem_rdata.
- inst_ready low for 4 cycles in VALID: Instruction, pc and inst_valid remain stable; pc_r is not updated; br_take toggling during the stall has no effect.
- Branch at pc=3010, imm16=16'hFFFC, br_take=1: next fetch addr = 3004. Same pc with jmp=1, Target=26'h0000C40: next fetch addr = 3100. jr=1, jmp=1, jr_addr=3400: next fetch addr = 3400.
- rst_n pulsed low during FETCH, then imem_ack arrives one cycle after release: ack is ignored, fetch restarts at 3000, inst_cnt=0.
- With IFU_ALIGN_CHK_EN, jr_addr=3402: no imem_req; inst_valid=1, Instruction=0, adel=1, pc=3402. Without the macro, the next fetch addr = 3400.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the PC, fetches words over a req/ack handshake and hands them
// to decode over valid/ready. Optional misaligned-PC trap is enabled by IFU_ALIGN_CHK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        br_take,
    input  logic [15:0] imm16,
    input  logic        jmp,
    input  logic [25:0] Target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] inst_cnt
`ifdef IFU_ALIGN_CHK_EN
    ,
    output logic        adel
`endif
);

    typedef enum logic [1:0] {StRst, StFetch, StValid} state_e;

    state_e      state_r, state_d;
    logic [31:0] pc_r, inst_r, cnt_r;
    logic [31:0] br_off, next_pc, pc_load;
    logic        consume, fetch_skip;

    assign consume = (state_r == StValid) && inst_ready;
    assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        if (jr) begin
            next_pc = jr_addr;
        end else if (jmp) begin
            next_pc = {pc4[31:28], Target, 2'b00};
        end else if (br_take) begin
            next_pc = pc4 + br_off;
        end else begin
            next_pc = pc4;
        end
    end

`ifdef IFU_ALIGN_CHK_EN
    logic adel_r;

    // A misaligned target is still loaded; the following slot becomes a NOP flagged with adel.
    assign pc_load    = next_pc;
    assign fetch_skip = adel_r;
    assign adel       = adel_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adel_r <= 1'b0;
        end else if (consume) begin
            adel_r <= (next_pc[1:0] != 2'b00);
        end
    end
`else
    assign pc_load    = next_pc & 32'hFFFF_FFFC;
    assign fetch_skip = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= StRst;
        end else begin
            state_r <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_r;
        unique case (state_r)
            StRst:   state_d = StFetch;
            StFetch: if (fetch_skip || imem_ack) state_d = StValid;
            StValid: if (inst_ready) state_d = StFetch;
            default: state_d = StRst;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req   = (state_r == StFetch) && !fetch_skip;
        inst_valid = (state_r == StValid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= RESET_PC;
            inst_r <= NOP_WORD;
            cnt_r  <= 32'd0;
        end else begin
            if (state_r == StFetch) begin
                if (fetch_skip) begin
                    inst_r <= NOP_WORD;
                end else if (imem_ack) begin
                    inst_r <= imem_rdata;
                end
            end
            if (consume) begin
                pc_r  <= pc_load;
                cnt_r <= cnt_r + 32'd1;
            end
        end
    end

    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign pc4         = pc_r + 32'd4;
    assign Instruction = inst_r;
    assign inst_cnt    = cnt_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; memory returns addr ^ 32'hC0DE_0000.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] Instruction, pc, pc4, inst_cnt, jr_addr;
    logic        inst_valid, inst_ready, br_take, jmp, jr;
    logic [15:0] imm16;
    logic [25:0] Target;
`ifdef IFU_ALIGN_CHK_EN
    logic        adel;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_cnt = 32'd0;

    localparam logic [31:0] MemKey = 32'hC0DE_0000;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ MemKey;

    inst_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .Instruction(Instruction),
        .pc         (pc),
        .pc4        (pc4),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .br_take    (br_take),
        .imm16      (imm16),
        .jmp        (jmp),
        .Target     (Target),
        .jr         (jr),
        .jr_addr    (jr_addr),
        .inst_cnt   (inst_cnt)
`ifdef IFU_ALIGN_CHK_EN
        ,
        .adel       (adel)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge in FETCH with inst_ready=1 and redirect inputs already set.
    task automatic run_insn(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_next);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, exp_pc);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_instr"}, Instruction, exp_pc ^ MemKey);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        check({tag, "_next"}, imem_addr, exp_next);
        check({tag, "_cnt"}, inst_cnt, exp_cnt);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; inst_ready = 1'b1;
        br_take = 1'b0; imm16 = 16'h0; jmp = 1'b0; Target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc", pc, 32'h3000);
        check("rst_pc4", pc4, 32'h3004);
        check("rst_instr", Instruction, 32'h0);
        check("rst_cnt", inst_cnt, 32'd0);
        rst_n = 1'b1;
        #1 check("rel_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        // Sequential stream, one instruction per two cycles
        run_insn("seq0", 32'h3000, 32'h3004);
        run_insn("seq1", 32'h3004, 32'h3008);
        run_insn("seq2", 32'h3008, 32'h300C);
        check("seq_cnt3", inst_cnt, 32'd3);

        // Ack delayed three cycles
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h300C);
            check("wait_valid", {31'd0, inst_valid}, 32'd0);
            @(negedge clk);
        end
        inst_ready = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("ack_valid", {31'd0, inst_valid}, 32'd1);
        check("ack_instr", Instruction, 32'h300C ^ MemKey);

        // Stall four cycles in VALID with br_take toggling
        imm16 = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            br_take = ~br_take;
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_pc", pc, 32'h300C);
            check("stall_instr", Instruction, 32'h300C ^ MemKey);
            check("stall_cnt", inst_cnt, 32'd3);
            @(negedge clk);
        end
        br_take = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        exp_cnt = 32'd4;
        check("stall_next", imem_addr, 32'h3010);
        check("stall_cnt4", inst_cnt, 32'd4);

        // Redirects
        br_take = 1'b1; imm16 = 16'hFFFC;
        run_insn("br", 32'h3010, 32'h3004);
        br_take = 1'b0; jr = 1'b1; jr_addr = 32'h3010;
        run_insn("jr0", 32'h3004, 32'h3010);
        jr = 1'b0; jmp = 1'b1; Target = 26'h0000C40;
        run_insn("jmp", 32'h3010, 32'h3100);
        jmp = 1'b0; jr = 1'b1; jr_addr = 32'h3010;
        run_insn("jr1", 32'h3100, 32'h3010);
        jmp = 1'b1; jr_addr = 32'h3400;
        run_insn("jrprio", 32'h3010, 32'h3400);
        jmp = 1'b0; jr_addr = 32'hFFFF_FFFC;
        run_insn("jrtop", 32'h3400, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0);
        jr = 1'b0;
        run_insn("wrap", 32'hFFFF_FFFC, 32'h0);

        // Misaligned jr target
        jr = 1'b1; jr_addr = 32'h3402;
`ifdef IFU_ALIGN_CHK_EN
        run_insn("mis", 32'h0, 32'h3402);
        check("mis_noreq", {31'd0, imem_req}, 32'd0);
        jr_addr = 32'h3000;
        @(negedge clk);
        check("adel_valid", {31'd0, inst_valid}, 32'd1);
        check("adel_instr", Instruction, 32'h0);
        check("adel_flag", {31'd0, adel}, 32'd1);
        check("adel_pc", pc, 32'h3402);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        check("adel_clr", {31'd0, adel}, 32'd0);
        check("adel_next", imem_addr, 32'h3000);
`else
        run_insn("mis", 32'h0, 32'h3400);
        check("mis_req", {31'd0, imem_req}, 32'd1);
`endif
        jr = 1'b0;

        // Reset mid-fetch with a late ack after release
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_pc", pc, 32'h3000);
        check("mid_rst_cnt", inst_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_req", {31'd0, imem_req}, 32'd1);
        check("late_addr", imem_addr, 32'h3000);
        check("late_valid", {31'd0, inst_valid}, 32'd0);
        check("late_cnt", inst_cnt, 32'd0);
        @(negedge clk);
        check("late_still", {31'd0, inst_valid}, 32'd0);
        exp_cnt = 32'd0;
        run_insn("restart", 32'h3000, 32'h3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
